// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control unit: state codes,
// opcode/funct values, ALU operation codes and datapath mux selects.
package mips_ctrl_pkg;

    localparam logic [3:0] S_RESET    = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_EXEC_R   = 4'd3;
    localparam logic [3:0] S_R_WB     = 4'd4;
    localparam logic [3:0] S_EXEC_I   = 4'd5;
    localparam logic [3:0] S_I_WB     = 4'd6;
    localparam logic [3:0] S_MEM_ADDR = 4'd7;
    localparam logic [3:0] S_MEM_RD   = 4'd8;
    localparam logic [3:0] S_MEM_WB   = 4'd9;
    localparam logic [3:0] S_MEM_WR   = 4'd10;
    localparam logic [3:0] S_BRANCH   = 4'd11;
    localparam logic [3:0] S_JUMP     = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_OR  = 6'b100101;

    localparam logic [2:0] ALU_OP_NONE  = 3'b000;
    localparam logic [2:0] ALU_OP_RTYPE = 3'b111;
    localparam logic [2:0] ALU_OP_ADD   = 3'b100;
    localparam logic [2:0] ALU_OP_OR    = 3'b010;
    localparam logic [2:0] ALU_OP_LUI   = 3'b001;

    localparam logic [1:0] ALU_SRC_B_RT      = 2'b00;
    localparam logic [1:0] ALU_SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] ALU_SRC_B_IMM     = 2'b10;
    localparam logic [1:0] ALU_SRC_B_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        CLS_NONE,
        CLS_RTYPE,
        CLS_ADDI,
        CLS_ORI,
        CLS_LUI,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_J
    } instr_class_t;

    // ALU operation for the immediate-arithmetic execute step.
    function automatic logic [2:0] imm_alu_op(input instr_class_t cls);
        logic [2:0] op;
        op = ALU_OP_ADD;
        case (cls)
            CLS_ORI: op = ALU_OP_OR;
            CLS_LUI: op = ALU_OP_LUI;
            default: op = ALU_OP_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Bundle between the control FSM and the datapath: IR fields and status in,
// enables, mux selects and ALU control out.
interface multicycle_control_fsm_if #(
    parameter int OPCODE_W = 6,
    parameter int STATE_W  = 4
);
    logic [OPCODE_W-1:0] opcode_i;
    logic [OPCODE_W-1:0] funct_i;
    logic                zero_i;
    logic                mem_ready_i;

    logic                pc_write_o;
    logic                pc_write_cond_o;
    logic                i_or_d_o;
    logic                mem_read_o;
    logic                mem_write_o;
    logic                ir_write_o;
    logic                reg_dst_o;
    logic                mem_to_reg_o;
    logic                reg_write_o;
    logic                alu_src_a_o;
    logic [1:0]          alu_src_b_o;
    logic [1:0]          pc_source_o;
    logic [2:0]          alu_op_o;
    logic [OPCODE_W-1:0] alu_function_o;
    logic                illegal_instr_o;
    logic [STATE_W-1:0]  state_o;

    modport master (
        input  opcode_i, funct_i, zero_i, mem_ready_i,
        output pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o,
               ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o,
               alu_src_b_o, pc_source_o, alu_op_o, alu_function_o,
               illegal_instr_o, state_o
    );

    modport slave (
        output opcode_i, funct_i, zero_i, mem_ready_i,
        input  pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o,
               ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o,
               alu_src_b_o, pc_source_o, alu_op_o, alu_function_o,
               illegal_instr_o, state_o
    );

endinterface

// File: rtl/multicycle_control_fsm_decoder.sv
// Combinational opcode/funct classifier; anything outside the supported
// instruction subset is flagged illegal and classed as CLS_NONE.
module control_opcode_decoder
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic [OPCODE_W-1:0] funct_i,
    output instr_class_t        class_o,
    output logic                illegal_o
);

    always_comb begin
        class_o   = CLS_NONE;
        illegal_o = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                if (funct_i == FN_ADD || funct_i == FN_SUB || funct_i == FN_OR) begin
                    class_o = CLS_RTYPE;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OP_ADDI: class_o = CLS_ADDI;
            OP_ORI:  class_o = CLS_ORI;
            OP_LUI:  class_o = CLS_LUI;
            OP_LW:   class_o = CLS_LW;
            OP_SW:   class_o = CLS_SW;
            OP_BEQ:  class_o = CLS_BEQ;
            OP_J:    class_o = CLS_J;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS main control FSM: Moore decode of datapath controls from
// the registered state, with the FETCH PC/IR loads gated by mem_ready_i.
module multicycle_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int STATE_W  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    multicycle_control_fsm_if.master bus
);

    logic [3:0]          state_q, state_d;
    instr_class_t        cls_q, cls_d;

    instr_class_t        dec_cls;
    logic                dec_illegal;

    logic                pc_write;
    logic                pc_write_cond;
    logic                i_or_d;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [1:0]          pc_source;
    logic [2:0]          alu_op;
    logic [OPCODE_W-1:0] alu_function;
    logic                illegal_instr;

    control_opcode_decoder #(
        .OPCODE_W (OPCODE_W)
    ) u_decoder (
        .opcode_i  (bus.opcode_i),
        .funct_i   (bus.funct_i),
        .class_o   (dec_cls),
        .illegal_o (dec_illegal)
    );

    // The instruction class is captured in DECODE so later states do not
    // depend on the IR fields (EXEC_I op select, lw/sw split after MEM_ADDR).
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                if (bus.mem_ready_i) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                cls_d = dec_cls;
                case (dec_cls)
                    CLS_RTYPE:                  state_d = S_EXEC_R;
                    CLS_ADDI, CLS_ORI, CLS_LUI: state_d = S_EXEC_I;
                    CLS_LW, CLS_SW:             state_d = S_MEM_ADDR;
                    CLS_BEQ:                    state_d = S_BRANCH;
                    CLS_J:                      state_d = S_JUMP;
                    default:                    state_d = S_FETCH;
                endcase
            end
            S_EXEC_R:   state_d = S_R_WB;
            S_R_WB:     state_d = S_FETCH;
            S_EXEC_I:   state_d = S_I_WB;
            S_I_WB:     state_d = S_FETCH;
            S_MEM_ADDR: state_d = (cls_q == CLS_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (bus.mem_ready_i) begin
                    state_d = S_MEM_WB;
                end
            end
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR: begin
                if (bus.mem_ready_i) begin
                    state_d = S_FETCH;
                end
            end
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RESET;
            cls_q   <= CLS_NONE;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ALU_SRC_B_RT;
        pc_source     = PC_SRC_ALU;
        alu_op        = ALU_OP_NONE;
        alu_function  = '0;
        illegal_instr = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = ALU_SRC_B_FOUR;
                alu_op    = ALU_OP_ADD;
                pc_write  = bus.mem_ready_i;
                ir_write  = bus.mem_ready_i;
            end
            S_DECODE: begin
                // Branch target is precomputed into ALUOut here.
                alu_src_b     = ALU_SRC_B_IMM_SH2;
                alu_op        = ALU_OP_ADD;
                illegal_instr = dec_illegal;
            end
            S_EXEC_R: begin
                alu_src_a    = 1'b1;
                alu_src_b    = ALU_SRC_B_RT;
                alu_op       = ALU_OP_RTYPE;
                alu_function = bus.funct_i;
            end
            S_R_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = ALU_SRC_B_IMM;
                alu_op    = imm_alu_op(cls_q);
            end
            S_I_WB: begin
                reg_write = 1'b1;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALU_SRC_B_IMM;
                alu_op    = ALU_OP_ADD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = ALU_SRC_B_RT;
                alu_op        = ALU_OP_RTYPE;
                alu_function  = FN_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PC_SRC_ALUOUT;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PC_SRC_JUMP;
            end
            default: ;
        endcase
    end

    assign bus.pc_write_o      = pc_write;
    assign bus.pc_write_cond_o = pc_write_cond;
    assign bus.i_or_d_o        = i_or_d;
    assign bus.mem_read_o      = mem_read;
    assign bus.mem_write_o     = mem_write;
    assign bus.ir_write_o      = ir_write;
    assign bus.reg_dst_o       = reg_dst;
    assign bus.mem_to_reg_o    = mem_to_reg;
    assign bus.reg_write_o     = reg_write;
    assign bus.alu_src_a_o     = alu_src_a;
    assign bus.alu_src_b_o     = alu_src_b;
    assign bus.pc_source_o     = pc_source;
    assign bus.alu_op_o        = alu_op;
    assign bus.alu_function_o  = alu_function;
    assign bus.illegal_instr_o = illegal_instr;
    assign bus.state_o         = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed control-word checks plus random
// instructions scored against a per-instruction cycle/pulse-count model.
module tb_multicycle_control_fsm;

    localparam int K_R    = 0;
    localparam int K_ADDI = 1;
    localparam int K_ORI  = 2;
    localparam int K_LUI  = 3;
    localparam int K_LW   = 4;
    localparam int K_SW   = 5;
    localparam int K_BEQ  = 6;
    localparam int K_J    = 7;
    localparam int K_ILL  = 8;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    multicycle_control_fsm_if #(.OPCODE_W(6), .STATE_W(4)) bus ();

    multicycle_control_fsm #(.OPCODE_W(6), .STATE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 'h%0h required 'h%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({bus.pc_write_o, bus.pc_write_cond_o, bus.i_or_d_o, bus.mem_read_o,
                    bus.mem_write_o, bus.ir_write_o, bus.reg_dst_o, bus.mem_to_reg_o,
                    bus.reg_write_o, bus.alu_src_a_o, bus.alu_src_b_o, bus.pc_source_o,
                    bus.alu_op_o, bus.alu_function_o, bus.illegal_instr_o, bus.state_o});
    endfunction

    function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00:   return (fn == 6'h20 || fn == 6'h22 || fn == 6'h25) ? K_R : K_ILL;
            6'h08:   return K_ADDI;
            6'h0D:   return K_ORI;
            6'h0F:   return K_LUI;
            6'h23:   return K_LW;
            6'h2B:   return K_SW;
            6'h04:   return K_BEQ;
            6'h02:   return K_J;
            default: return K_ILL;
        endcase
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Runs one instruction from FETCH back to FETCH, inserting fw wait cycles
    // in the fetch and mw in the data-memory access, and scores the totals.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fw, input int mw, input string tag);
        int base_lat[9] = '{4, 4, 4, 4, 5, 4, 3, 3, 2};
        int exec_op[9]  = '{7, 4, 2, 1, 4, 4, 7, 0, 0};
        int k, fc, mc, cyc, regw, memw, memr, pcw, irw, ill, pcc, m2r, ex_op, ex_fn;
        int e_cyc, e_fn;
        bit left, done;
        k = kind_of(op, fn);
        fc = 0; mc = 0; cyc = 0; regw = 0; memw = 0; memr = 0; pcw = 0; irw = 0;
        ill = 0; pcc = 0; m2r = 0; ex_op = 0; ex_fn = 0; left = 0; done = 0;
        bus.opcode_i = op;
        bus.funct_i  = fn;
        while (!done && cyc < 60) begin
            if (bus.mem_read_o && !bus.i_or_d_o) begin
                bus.mem_ready_i = (fc == fw);
                fc++;
            end else if (bus.i_or_d_o) begin
                bus.mem_ready_i = (mc == mw);
                mc++;
            end else begin
                bus.mem_ready_i = 1'($urandom);
            end
            bus.zero_i = 1'($urandom);
            #1;
            regw += int'(bus.reg_write_o);
            memw += int'(bus.mem_write_o);
            memr += int'(bus.mem_read_o);
            pcw  += int'(bus.pc_write_o);
            irw  += int'(bus.ir_write_o);
            ill  += int'(bus.illegal_instr_o);
            pcc  += int'(bus.pc_write_cond_o);
            m2r  += int'(bus.mem_to_reg_o);
            if (bus.alu_src_a_o) begin
                ex_op = int'(bus.alu_op_o);
                ex_fn = int'(bus.alu_function_o);
            end
            if (bus.state_o != 4'd1) left = 1;
            cyc++;
            @(negedge clk);
            if (left && bus.state_o == 4'd1) done = 1;
        end
        if (!done) chk({tag, "_timeout"}, 32'(cyc), 32'(0));
        e_cyc = base_lat[k] + fw + ((k == K_LW || k == K_SW) ? mw : 0);
        e_fn  = (k == K_R) ? int'(fn) : (k == K_BEQ ? 'h22 : 0);
        chk({tag, "_cycles"},   32'(cyc),   32'(e_cyc));
        chk({tag, "_regwrite"}, 32'(regw),  32'((k <= K_LW) ? 1 : 0));
        chk({tag, "_memwrite"}, 32'(memw),  32'((k == K_SW) ? mw + 1 : 0));
        chk({tag, "_memread"},  32'(memr),  32'(fw + 1 + ((k == K_LW) ? mw + 1 : 0)));
        chk({tag, "_pcwrite"},  32'(pcw),   32'((k == K_J) ? 2 : 1));
        chk({tag, "_irwrite"},  32'(irw),   32'(1));
        chk({tag, "_illegal"},  32'(ill),   32'((k == K_ILL) ? 1 : 0));
        chk({tag, "_pccond"},   32'(pcc),   32'((k == K_BEQ) ? 1 : 0));
        chk({tag, "_memtoreg"}, 32'(m2r),   32'((k == K_LW) ? 1 : 0));
        chk({tag, "_aluop"},    32'(ex_op), 32'(exec_op[k]));
        chk({tag, "_alufunc"},  32'(ex_fn), 32'(e_fn));
    endtask

    initial begin
        logic [5:0] legal_op[10] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02};
        logic [5:0] legal_fn[10] = '{6'h20, 6'h22, 6'h25, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
        logic [5:0] op, fn;
        int sel;
        n_checks = 0;
        n_pass   = 0;
        reset = 1'b0;
        bus.opcode_i = '0;
        bus.funct_i = '0;
        bus.zero_i = 1'b0;
        bus.mem_ready_i = 1'b0;

        #12;
        chk("reset_outs", all_outs(), 32'(0));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("release_state", 32'(bus.state_o), 32'(1));
        chk("release_memread", 32'(bus.mem_read_o), 32'(1));

        // add, zero wait states
        bus.opcode_i = 6'h00; bus.funct_i = 6'h20; bus.mem_ready_i = 1'b1;
        #1;
        chk("add_fetch_pcw", 32'(bus.pc_write_o), 32'(1));
        chk("add_fetch_irw", 32'(bus.ir_write_o), 32'(1));
        step();
        chk("add_dec_state", 32'(bus.state_o), 32'(2));
        chk("add_dec_srcb", 32'(bus.alu_src_b_o), 32'(3));
        step();
        chk("add_exec_aluop", 32'(bus.alu_op_o), 32'(7));
        chk("add_exec_func", 32'(bus.alu_function_o), 32'(6'h20));
        chk("add_exec_srca", 32'(bus.alu_src_a_o), 32'(1));
        step();
        chk("add_wb_regw", 32'(bus.reg_write_o), 32'(1));
        chk("add_wb_regdst", 32'(bus.reg_dst_o), 32'(1));
        step();
        chk("add_back_fetch", 32'(bus.state_o), 32'(1));

        // beq
        bus.opcode_i = 6'h04; bus.funct_i = 6'h00;
        step();
        step();
        chk("beq_aluop", 32'(bus.alu_op_o), 32'(7));
        chk("beq_func", 32'(bus.alu_function_o), 32'(6'h22));
        chk("beq_pccond", 32'(bus.pc_write_cond_o), 32'(1));
        chk("beq_pcsrc", 32'(bus.pc_source_o), 32'(1));
        step();
        chk("beq_back_fetch", 32'(bus.state_o), 32'(1));

        // lui
        bus.opcode_i = 6'h0F;
        step();
        step();
        chk("lui_aluop", 32'(bus.alu_op_o), 32'(1));
        chk("lui_srcb", 32'(bus.alu_src_b_o), 32'(2));
        step();
        chk("lui_wb_regw", 32'(bus.reg_write_o), 32'(1));
        chk("lui_wb_regdst", 32'(bus.reg_dst_o), 32'(0));
        step();

        // illegal opcode, then illegal R-type funct
        bus.opcode_i = 6'h3F;
        step();
        chk("illop_pulse", 32'(bus.illegal_instr_o), 32'(1));
        step();
        chk("illop_state", 32'(bus.state_o), 32'(1));
        chk("illop_pulse_end", 32'(bus.illegal_instr_o), 32'(0));
        chk("illop_nowrite", 32'({bus.reg_write_o, bus.mem_write_o}), 32'(0));
        bus.opcode_i = 6'h00; bus.funct_i = 6'h00;
        step();
        chk("illfn_pulse", 32'(bus.illegal_instr_o), 32'(1));
        step();
        chk("illfn_state", 32'(bus.state_o), 32'(1));
        chk("illfn_nowrite", 32'({bus.reg_write_o, bus.mem_write_o, bus.illegal_instr_o}), 32'(0));

        // reset asserted while lw waits in MEM_RD
        bus.opcode_i = 6'h23;
        step();
        step();
        bus.mem_ready_i = 1'b0;
        step();
        chk("lw_memrd_state", 32'(bus.state_o), 32'(8));
        #2;
        reset = 1'b0;
        #1;
        chk("midreset_outs", all_outs(), 32'(0));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_rel_state", 32'(bus.state_o), 32'(1));
        chk("midreset_rel_memread", 32'(bus.mem_read_o), 32'(1));
        @(negedge clk);

        run_instr(6'h23, 6'h00, 2, 3, "lw_waits");
        run_instr(6'h2B, 6'h11, 1, 2, "sw_b2b");
        run_instr(6'h02, 6'h00, 0, 0, "j_b2b");

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 11);
            if (sel < 10) begin
                op = legal_op[sel];
                fn = (sel < 3) ? legal_fn[sel] : 6'($urandom);
            end else if (sel == 10) begin
                fn = 6'($urandom);
                do op = 6'($urandom); while (kind_of(op, 6'h20) != K_ILL);
            end else begin
                op = 6'h00;
                do fn = 6'($urandom); while (kind_of(op, fn) != K_ILL);
            end
            run_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multicycle MIPS main control unit. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives all datapath enables and muxes, plus the alu_op/alu_function pair consumed directly by the ALU control stage. It sits between the instruction register's opcode/funct fields and the datapath.

Parameters:
OPCODE_W, 6, opcode and funct field width
STATE_W, 4, state register width (exported on state_o)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
opcode_i  in  6  IR[31:26]
funct_i  in  6  IR[5:0]
zero_i  in  1  ALU zero flag
mem_ready_i  in  1  memory access complete this cycle
pc_write_o  out  1  unconditional PC load
pc_write_cond_o  out  1  PC load if zero_i (beq)
i_or_d_o  out  1  0 = PC address, 1 = ALUOut address
mem_read_o  out  1  memory read request
mem_write_o  out  1  memory write request
ir_write_o  out  1  IR load
reg_dst_o  out  1  1 = rd, 0 = rt
mem_to_reg_o  out  1  1 = MDR, 0 = ALUOut
reg_write_o  out  1  register file write
alu_src_a_o  out  1  0 = PC, 1 = rs
alu_src_b_o  out  2  00 = rt, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
pc_source_o  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
alu_op_o  out  3  to ALU control stage
alu_function_o  out  6  to ALU control stage
illegal_instr_o  out  1  one-cycle pulse on unsupported opcode/funct
state_o  out  4  current state, for debug

Behaviour:
- Moore outputs, decoded combinationally from the registered state. Exceptions: pc_write_o and ir_write_o in FETCH are qualified by mem_ready_i.
- Reset (reset=0) forces S_RESET asynchronously. All outputs are 0 in S_RESET. The first cycle after release goes to FETCH. Reset mid-instruction aborts with no further writes.
- alu_function_o = funct_i in EXEC_R. In BRANCH it is 6'b100010 (sub) with alu_op_o=111. It is 0 elsewhere.
- alu_op codes: 111 R-type, 100 add, 010 or, 001 lui. Idle states drive 000.
- States and transitions:
 - FETCH: mem_read=1, i_or_d=0, src_a=0, src_b=01, alu_op=100, pc_source=00. Stays while mem_ready_i=0. On mem_ready_i=1: ir_write=1, pc_write=1, next state DECODE.
 - DECODE: src_a=0, src_b=11, alu_op=100 (branch target into ALUOut). Next state by opcode:
   - 000000 → EXEC_R; funct must be 100000, 100010 or 100101, else illegal.
   - 001000 addi → EXEC_I
   - 001101 ori → EXEC_I
   - 001111 lui → EXEC_I
   - 100011 lw / 101011 sw → MEM_ADDR
   - 000100 beq → BRANCH
   - 000010 j → JUMP
   - otherwise illegal_instr_o=1 for this cycle, next FETCH.
 - EXEC_R: src_a=1, src_b=00, alu_op=111 → R_WB.
 - R_WB: reg_dst=1, mem_to_reg=0, reg_write=1 → FETCH.
 - EXEC_I: src_a=1, src_b=10, alu_op = 100 (addi), 010 (ori) or 001 (lui) → I_WB.
 - I_WB: reg_dst=0, mem_to_reg=0, reg_write=1 → FETCH.
 - MEM_ADDR: src_a=1, src_b=10, alu_op=100 → MEM_RD (lw) or MEM_WR (sw).
 - MEM_RD: mem_read=1, i_or_d=1. Waits on mem_ready_i, then → MEM_WB.
 - MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1 → FETCH.
 - MEM_WR: mem_write=1, i_or_d=1. Waits on mem_ready_i, then → FETCH.
 - BRANCH: src_a=1, src_b=00, pc_write_cond=1, pc_source=01 → FETCH.
 - JUMP: pc_write=1, pc_source=10 → FETCH.
- Zero-wait latency in cycles: R/I-type 4, lw 5, sw 4, beq 3, j 3. Each wait cycle adds 1.
- opcode_i/funct_i are sampled only in DECODE and EXEC_R (the IR is stable then). Undefined states recover to FETCH.

Decomposition:
- Shared package/include mips_ctrl_pkg:
 - state encodings (S_RESET=0, FETCH=1 … JUMP=12)
 - opcode constants
 - funct constants (ADD/SUB/OR)
 - ALU_OP_* codes (111/100/010/001)
 - ALU_SRC_B_* and PC_SRC_* constants
- One sub-module: control_opcode_decoder (combinational), which maps opcode/funct to instruction class plus an illegal flag. The FSM instantiates it.

Test Plan:
- Reset low mid-MEM_RD → state_o=0 and all enables 0 immediately. One cycle after release, state_o=FETCH with mem_read_o=1.
- add (opcode 0, funct 100000), mem_ready_i=1 → 4 cycles. EXEC_R gives alu_op_o=111, alu_function_o=100000. R_WB gives reg_write_o=1, reg_dst_o=1.
- lw with mem_ready_i low 2 cycles in FETCH and 3 cycles in MEM_RD → 10 cycles total. ir_write_o pulses only on the ready cycle. MEM_WB gives mem_to_reg_o=1.
- beq → BRANCH gives alu_op_o=111, alu_function_o=100010, pc_write_cond_o=1, pc_source_o=01. lui → EXEC_I gives alu_op_o=001.
- opcode 111111 → illegal_instr_o=1 for one cycle in DECODE, then FETCH with no reg_write/mem_write. Same for opcode 0 with funct 000000.
- sw then j back-to-back → mem_write_o only in MEM_WR while waiting. JUMP gives pc_write_o=1, pc_source_o=10.
